shift_serializer: RTL and testbench

Upstream feeder for the N-bit bidirectional shift register. Accepts a parallel word and a direction through a valid/ready handshake. Drives the shifter's serial input, direction select and shift enable for exactly N cycles, so that when the burst ends the shift register holds the accepted word unchanged. Pulses done at the end of each burst. Sits between the control/test logic and the shifter.

---
 rtl/shift_ser_pkg.sv | 25 ++
 rtl/shift_serializer_counter.sv | 39 +++
 rtl/shift_serializer.sv | 173 +++++++++++++++++
 tb/tb_shift_serializer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_ser_pkg.sv
// Shared types, constants and helpers for the shift_serializer block.
// Optional feature macro: SHIFT_SER_PARITY_EN (appends an even-parity bit to each burst).
package shift_ser_pkg;

   // Burst sequencing states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Direction encoding shared with the downstream shifter's s input.
   localparam logic DIR_LEFT  = 1'b0;  // insert at LSB, word sent MSB first
   localparam logic DIR_RIGHT = 1'b1;  // insert at MSB, word sent LSB first

   // Widest word the parity helper accepts; callers zero-extend, which leaves
   // the XOR unchanged.
   localparam int PAR_W = 64;

   // Even-parity bit of a word: XOR of all its bits.
   function automatic logic even_parity(input logic [PAR_W-1:0] word);
      return ^word;
   endfunction

endpackage : shift_ser_pkg

// File: rtl/shift_serializer_counter.sv
// ser_bit_counter: up-counter with synchronous clear and enable. It saturates
// at LIMIT and flags the terminal count, so it never wraps.
module ser_bit_counter #(
   parameter int W     = 3,
   parameter int LIMIT = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: clear wins over enable; hold once the limit is reached.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !tc_o) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == W'(LIMIT));

endmodule : ser_bit_counter

// File: rtl/shift_serializer.sv
// shift_serializer: accepts a parallel word plus direction over valid/ready and
// feeds it bit by bit into an N-bit bidirectional shifter, so the shifter holds
// the word once the burst completes. Pulses done one cycle after the last shift.
// Optional feature macro: SHIFT_SER_PARITY_EN (one extra shift cycle carrying
// the word's even parity; done moves one cycle later).
module shift_serializer
   import shift_ser_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         in_dir,
   output logic         ser_bit,
   output logic         ser_dir,
   output logic         ser_en,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(N + 1);

`ifdef SHIFT_SER_PARITY_EN
   localparam int LAST_CNT = N;      // N data cycles plus one parity cycle
`else
   localparam int LAST_CNT = N - 1;  // N data cycles
`endif

   state_e         state_q, state_d;
   logic [N-1:0]   word_q, word_d;
   logic           dir_q, dir_d;
   logic           in_ready_q, in_ready_d;
   logic           ser_bit_q, ser_bit_d;
   logic           ser_dir_q, ser_dir_d;
   logic           ser_en_q, ser_en_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic           accept;
   logic [CW-1:0]  cnt;
   logic           cnt_tc;
   logic [CW-1:0]  next_idx;
   logic [N-1:0]   word_lsb_view;
   logic [N-1:0]   word_msb_view;
   logic           next_bit;

   // Counts shift cycles of the current burst; cleared when a word is accepted.
   ser_bit_counter #(
      .W     (CW),
      .LIMIT (LAST_CNT)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (accept),
      .en_i  (state_q == SHIFT),
      .cnt_o (cnt),
      .tc_o  (cnt_tc)
   );

   // Bit to present on the cycle after the current one. Shifting the word
   // rather than indexing it keeps the select width-clean and makes an
   // index of N read as 0 instead of going out of range.
   always_comb begin
      next_idx      = cnt + CW'(1);
      word_lsb_view = word_q >> next_idx;
      word_msb_view = word_q << next_idx;
      next_bit      = (dir_q == DIR_RIGHT) ? word_lsb_view[0] : word_msb_view[N-1];
`ifdef SHIFT_SER_PARITY_EN
      if (next_idx == CW'(N)) begin
         next_bit = even_parity(PAR_W'(word_q));
      end
`endif
   end

   // Next-state and registered-output logic for the burst sequencer.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
      state_d    = state_q;
      word_d     = word_q;
      dir_d      = dir_q;
      in_ready_d = in_ready_q;
      ser_bit_d  = ser_bit_q;
      ser_dir_d  = ser_dir_q;
      ser_en_d   = ser_en_q;
      busy_d     = busy_q;
      done_d     = done_q;
      accept     = 1'b0;

      unique case (state_q)
         IDLE: begin
            in_ready_d = 1'b1;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            ser_en_d   = 1'b0;
            if (in_valid && in_ready_q) begin
               accept     = 1'b1;
               word_d     = in_data;
               dir_d      = in_dir;
               state_d    = SHIFT;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
               ser_en_d   = 1'b1;
               ser_dir_d  = in_dir;
               // First bit comes straight from the input so it appears on the
               // cycle right after acceptance.
               ser_bit_d  = (in_dir == DIR_RIGHT) ? in_data[0] : in_data[N-1];
            end
         end

         SHIFT: begin
            if (cnt_tc) begin
               state_d  = DONE;
               ser_en_d = 1'b0;
               done_d   = 1'b1;
            end else begin
               ser_bit_d = next_bit;
            end
         end

         DONE: begin
            state_d    = IDLE;
            done_d     = 1'b0;
            busy_d     = 1'b0;
            in_ready_d = 1'b1;
         end

         default: begin
            state_d    = IDLE;
            in_ready_d = 1'b1;
            ser_en_d   = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
         end
      endcase
   end

   // State and output registers; synchronous reset abandons any burst.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         word_q     <= '0;
         dir_q      <= 1'b0;
         in_ready_q <= 1'b1;
         ser_bit_q  <= 1'b0;
         ser_dir_q  <= 1'b0;
         ser_en_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values together.
         state_q    <= state_d;
         word_q     <= word_d;
         dir_q      <= dir_d;
         in_ready_q <= in_ready_d;
         ser_bit_q  <= ser_bit_d;
         ser_dir_q  <= ser_dir_d;
         ser_en_q   <= ser_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign in_ready = in_ready_q;
   assign ser_bit  = ser_bit_q;
   assign ser_dir  = ser_dir_q;
   assign ser_en   = ser_en_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule : shift_serializer

// File: tb/tb_shift_serializer.sv
// Testbench for shift_serializer: cycle-level timeline model plus directed bursts.
// Honours SHIFT_SER_PARITY_EN when the build defines it.
module tb_shift_serializer;

   localparam int N = 4;
`ifdef SHIFT_SER_PARITY_EN
   localparam int L = N + 1;
`else
   localparam int L = N;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic         in_dir;
   logic         ser_bit;
   logic         ser_dir;
   logic         ser_en;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   shift_serializer #(.N(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_dir   (in_dir),
      .ser_bit  (ser_bit),
      .ser_dir  (ser_dir),
      .ser_en   (ser_en),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Bit sent on shift cycle k of a burst.
   function automatic logic bit_of(input logic [N-1:0] w, input logic d, input int k);
      if (k == N) return ^w;
      return d ? w[k] : w[N-1-k];
   endfunction

   // Timeline model: m_phase counts cycles since acceptance (0 = idle).
   int           m_phase = 0;
   logic [N-1:0] m_word  = '0;
   logic         m_wdir  = 1'b0;
   logic         m_bit   = 1'b0;
   logic         m_dir   = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_phase = 0;
         m_bit   = 1'b0;
         m_dir   = 1'b0;
      end else if (m_phase == 0) begin
         if (in_valid) begin
            m_word  = in_data;
            m_wdir  = in_dir;
            m_phase = 1;
         end
      end else if (m_phase == L + 1) begin
         m_phase = 0;
      end else begin
         m_phase++;
      end
      if (m_phase >= 1 && m_phase <= L) begin
         m_bit = bit_of(m_word, m_wdir, m_phase - 1);
         m_dir = m_wdir;
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (check_en) begin
         check("in_ready", 32'(in_ready), 32'(m_phase == 0));
         check("ser_en",   32'(ser_en),   32'(m_phase >= 1 && m_phase <= L));
         check("done",     32'(done),     32'(m_phase == L + 1));
         check("busy",     32'(busy),     32'(m_phase >= 1));
         check("ser_bit",  32'(ser_bit),  32'(m_bit));
         check("ser_dir",  32'(ser_dir),  32'(m_dir));
      end
   end

   // Downstream shifter model.
   logic [N-1:0] sh = '0;
   always @(posedge clk) begin
      if (ser_en === 1'b1) sh <= ser_dir ? {ser_bit, sh[N-1:1]} : {sh[N-2:0], ser_bit};
   end

   // One directed burst; starts and ends on a negedge.
   task automatic run_burst(input logic [N-1:0] d, input logic dir,
                            output logic [7:0] bits, output int nbits,
                            output int done_at, output int ready_at,
                            output logic [N-1:0] shreg);
      bits = '0; nbits = 0; done_at = -1; ready_at = -1; shreg = '0;
      in_valid = 1'b1; in_data = d; in_dir = dir;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; in_data = ~d; in_dir = ~dir;
      for (int k = 1; k <= L + 3; k++) begin
         if (ser_en) begin bits = {bits[6:0], ser_bit}; nbits++; end
         if (done && done_at < 0) begin done_at = k; shreg = sh; end
         if (in_ready && ready_at < 0) ready_at = k;
         @(negedge clk);
      end
   endtask

   logic [7:0]   bits;
   int           nbits, done_at, ready_at, accepts;
   logic [N-1:0] shreg;

   initial begin
      rst_n = 1'b0; in_valid = 1'b1; in_data = 4'hF; in_dir = 1'b1;
      @(posedge clk);
      check_en = 1'b1;
      // Reset held with in_valid high: nothing accepted.
      repeat (3) begin
         @(negedge clk);
         check("rst_ready", 32'(in_ready), 32'd1);
         check("rst_en",    32'(ser_en),   32'd0);
         check("rst_done",  32'(done),     32'd0);
         check("rst_busy",  32'(busy),     32'd0);
      end
      rst_n = 1'b1; in_valid = 1'b0;
      @(negedge clk);

      // Right shift, LSB first.
      run_burst(4'b1011, 1'b1, bits, nbits, done_at, ready_at, shreg);
      check("r_nbits",    32'(nbits),    32'(L));
`ifdef SHIFT_SER_PARITY_EN
      check("r_bits",     32'(bits),     32'b11011);
      check("r_shreg",    32'(shreg),    32'b1101);
`else
      check("r_bits",     32'(bits),     32'b1101);
      check("r_shreg",    32'(shreg),    32'b1011);
`endif
      check("r_done_at",  32'(done_at),  32'(L + 1));
      check("r_ready_at", 32'(ready_at), 32'(L + 2));

      // Left shift, MSB first.
      run_burst(4'b1011, 1'b0, bits, nbits, done_at, ready_at, shreg);
      check("l_nbits",    32'(nbits),    32'(L));
`ifdef SHIFT_SER_PARITY_EN
      check("l_bits",     32'(bits),     32'b10111);
      check("l_shreg",    32'(shreg),    32'b0111);
`else
      check("l_bits",     32'(bits),     32'b1011);
      check("l_shreg",    32'(shreg),    32'b1011);
`endif
      check("l_done_at",  32'(done_at),  32'(L + 1));
      check("l_ready_at", 32'(ready_at), 32'(L + 2));

      // A second pattern in each direction, checked by the model.
      run_burst(4'b0110, 1'b1, bits, nbits, done_at, ready_at, shreg);
      run_burst(4'b1000, 1'b0, bits, nbits, done_at, ready_at, shreg);

      // Continuous in_valid with changing data: one word per L+2 cycles.
      accepts = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 3 * (L + 2); i++) begin
         in_data = N'($urandom);
         in_dir  = 1'($urandom);
         if (in_ready) accepts++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("throughput", 32'(accepts), 32'd3);
      repeat (L + 3) @(negedge clk);

      // Reset after the second shift cycle: burst abandoned, no done.
      in_valid = 1'b1; in_data = 4'b1101; in_dir = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mrst_en",    32'(ser_en),   32'd0);
      check("mrst_busy",  32'(busy),     32'd0);
      check("mrst_ready", 32'(in_ready), 32'd1);
      check("mrst_done",  32'(done),     32'd0);
      rst_n = 1'b1;
      repeat (L + 2) begin
         @(negedge clk);
         check("mrst_nodone", 32'(done), 32'd0);
      end

      check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule : tb_shift_serializer
